pipeline_alu_vr: RTL and testbench
==================================

// Module: pipeline_alu_vr
// PURPOSE
//  Parametrised, handshaked successor of the fixed (A+B)^C pipeline: computes Q = (A op B) lop C.
//  Arithmetic op (add/sub) and logic op (xor/and/or/pass) are selectable per transaction.
//  Valid/ready on input and output; global-stall pipeline of DEPTH register stages.
//  Sits between operand sources and a consumer that may apply backpressure.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=1)
//  DEPTH  3  total register stages, input capture to output (>=3); stages 4..DEPTH are pure delay
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        synchronous clear of all stage valid bits
//  in_valid   in   1        operand set present
//  in_ready   out  1        block accepts operands this cycle
//  A, B, C    in   WIDTH    operands, unsigned
//  arith_sub  in   1        0: s = A+B, 1: s = A-B (modulo 2^WIDTH)
//  logic_sel  in   2        00: s^C, 01: s&C, 10: s|C, 11: s (C ignored)
//  out_valid  out  1        Q/carry valid
//  out_ready  in   1        consumer accepts Q this cycle
//  Q          out  WIDTH    result
//  carry      out  1        add: carry-out of A+B; sub: borrow (1 iff A<B)
// BEHAVIOUR
//  - Reset (rst=1, async): all stage data and valid bits 0; Q=0, carry=0, out_valid=0; in_ready=1 after reset.
//  - Global enable: en = out_ready | ~out_valid; all stages shift when en=1, hold when en=0.
//  - in_ready = en (combinational). Accept = in_valid & in_ready.
//  - Stage 1: capture A,B,C,arith_sub,logic_sel and valid=accept when en.
//  - Stage 2: s = {1'b0,A} +/- {1'b0,B}, WIDTH+1 bits; s[WIDTH] = carry/borrow; C, logic_sel delayed.
//  - Stage 3: r = s[WIDTH-1:0] lop C; carry forwarded unchanged.
//  - Stages 4..DEPTH: delay registers for r, carry, valid; last stage drives Q, carry, out_valid.
//  - Latency: exactly DEPTH enabled cycles from accept to out_valid=1; throughput 1/cycle when out_ready=1.
//  - Bubbles travel with the data and are not collapsed; an empty slot still costs a cycle.
//  - Backpressure: out_valid=1 & out_ready=0 freezes every stage; Q, carry stable until handshake.
//  - Handshake rules: out_valid is never dropped without out_ready=1 (except flush/reset); no transaction
//    is duplicated or lost.
//  - flush=1: all valid bits cleared next edge, data registers unchanged; flush overrides a same-cycle accept
//    (operands in that cycle are discarded); in_ready still reflects en.
//  - Wrap-around: results modulo 2^WIDTH; overflow reported only via carry.
//  - Reset mid-operation discards all in-flight transactions immediately (async).
//  - Operands and mode are sampled only on accept; changes while in_ready=0 have no effect.
// TESTING (WIDTH=4, DEPTH=3 unless noted)
//  1. rst pulse mid-stream -> out_valid=0, Q=0, carry=0 immediately; in_ready=1 after release.
//  2. A=3,B=5,C=6,add,xor, out_ready=1 -> out_valid 3 cycles later, Q=0xE, carry=0.
//  3. A=2,B=5,sub,pass -> Q=0xD, carry=1; A=F,B=1,C=0,add,xor -> Q=0x0, carry=1.
//  4. Stream 8 random sets, out_ready=1 -> 8 consecutive out_valid cycles, results match model in order.
//  5. Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, Q/carry frozen; release -> no loss or dup.
//  6. DEPTH=5: flush with 3 in flight -> out_valid=0 next cycle; new op after flush appears 5 cycles later.

Source files
------------

// File: rtl/pipeline_alu_vr.sv
// pipeline_alu_vr: handshaked pipeline computing Q = (A op B) lop C.
// Stage 1 captures operands, stage 2 adds/subtracts, stage 3 applies the
// logic op, and stages 4..DEPTH are pure delay. One global enable stalls
// every stage together. Bubbles are not collapsed.
module pipeline_alu_vr #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic             arith_sub,
   input  logic [1:0]       logic_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q,
   output logic             carry
);

   // Stage 3 plus the delay stages that follow it form the tail.
   localparam int NT = DEPTH - 2;

   // Applies the selected logic op to the arithmetic result.
   function automatic logic [WIDTH-1:0] apply_lop(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] c,
                                                  input logic [1:0]       sel);
      logic [WIDTH-1:0] r;
      case (sel)
         2'b00:   r = s ^ c;
         2'b01:   r = s & c;
         2'b10:   r = s | c;
         2'b11:   r = s;
         default: r = s;
      endcase
      return r;
   endfunction

   logic             en_s;
   logic             accept_s;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [WIDTH-1:0] s1_c_q;
   logic             s1_sub_q;
   logic [1:0]       s1_sel_q;

   logic [WIDTH:0]   s2_sum_d;
   logic             s2_valid_q;
   logic [WIDTH:0]   s2_sum_q;
   logic [WIDTH-1:0] s2_c_q;
   logic [1:0]       s2_sel_q;

   logic [WIDTH-1:0] s3_r_d;
   logic [WIDTH-1:0] t_r_q [NT];
   logic             t_c_q [NT];
   logic             t_v_q [NT];

   // Global enable: shift unless the output holds data the consumer refuses.
   always_comb begin
      en_s     = out_ready | ~out_valid;
      accept_s = in_valid & en_s;
   end

   assign in_ready  = en_s;
   assign out_valid = t_v_q[NT-1];
   assign Q         = t_r_q[NT-1];
   assign carry     = t_c_q[NT-1];

   // Arithmetic and logic results computed from the preceding stage registers.
   always_comb begin
      s2_sum_d = {(WIDTH+1){1'b0}};
      if (s1_sub_q) begin
         s2_sum_d = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      end else begin
         s2_sum_d = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      end
      s3_r_d = apply_lop(s2_sum_q[WIDTH-1:0], s2_c_q, s2_sel_q);
   end

   // Stage 1: operand and mode capture; valid only on an accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= {WIDTH{1'b0}};
         s1_b_q     <= {WIDTH{1'b0}};
         s1_c_q     <= {WIDTH{1'b0}};
         s1_sub_q   <= 1'b0;
         s1_sel_q   <= 2'b00;
      end else if (flush) begin
         s1_valid_q <= 1'b0;
      end else if (en_s) begin
         s1_valid_q <= accept_s;
         s1_a_q     <= A;
         s1_b_q     <= B;
         s1_c_q     <= C;
         s1_sub_q   <= arith_sub;
         s1_sel_q   <= logic_sel;
      end else begin
         s1_valid_q <= s1_valid_q;
      end
   end

   // Stage 2: add/subtract with carry or borrow in the top bit; C and mode delayed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= {(WIDTH+1){1'b0}};
         s2_c_q     <= {WIDTH{1'b0}};
         s2_sel_q   <= 2'b00;
      end else if (flush) begin
         s2_valid_q <= 1'b0;
      end else if (en_s) begin
         s2_valid_q <= s1_valid_q;
         s2_sum_q   <= s2_sum_d;
         s2_c_q     <= s1_c_q;
         s2_sel_q   <= s1_sel_q;
      end else begin
         s2_valid_q <= s2_valid_q;
      end
   end

   // Stage 3 and delay stages: logic op result and carry shifted toward the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NT; i++) begin
            t_v_q[i] <= 1'b0;
            t_r_q[i] <= {WIDTH{1'b0}};
            t_c_q[i] <= 1'b0;
         end
      end else if (flush) begin
         for (int i = 0; i < NT; i++) begin
            t_v_q[i] <= 1'b0;
         end
      end else if (en_s) begin
         t_v_q[0] <= s2_valid_q;
         t_r_q[0] <= s3_r_d;
         t_c_q[0] <= s2_sum_q[WIDTH];
         for (int i = 1; i < NT; i++) begin
            t_v_q[i] <= t_v_q[i-1];
            t_r_q[i] <= t_r_q[i-1];
            t_c_q[i] <= t_c_q[i-1];
         end
      end else begin
         for (int i = 0; i < NT; i++) begin
            t_v_q[i] <= t_v_q[i];
         end
      end
   end

endmodule

// File: tb/tb_pipeline_alu_vr.sv
// Directed self-checking bench for pipeline_alu_vr (DEPTH=3 and DEPTH=5 instances).
module tb_pipeline_alu_vr;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] A = 4'h0, B = 4'h0, C = 4'h0;
   logic       arith_sub = 1'b0;
   logic [1:0] logic_sel = 2'b00;
   logic       out_ready = 1'b0;

   logic       ir3, ov3, c3;
   logic [3:0] q3;
   logic       ir5, ov5, c5;
   logic [3:0] q5;

   int checks = 0;
   int errors = 0;

   // Vectors: A, B, C, sub, sel -> expected Q, carry (hand computed).
   logic [3:0] va [8] = '{4'h7, 4'h4, 4'hC, 4'h1, 4'h8, 4'hF, 4'h0, 4'h6};
   logic [3:0] vb [8] = '{4'h9, 4'hA, 4'h3, 4'h2, 4'h8, 4'hF, 4'h1, 4'h5};
   logic [3:0] vc [8] = '{4'hF, 4'h3, 4'h5, 4'hF, 4'h1, 4'hA, 4'hC, 4'h6};
   logic       vs [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [1:0] vl [8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01};
   logic [3:0] vq [8] = '{4'h0, 4'hB, 4'hC, 4'h3, 4'h1, 4'hA, 4'hC, 4'h2};
   logic       vk [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   pipeline_alu_vr #(.WIDTH(4), .DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
      .A(A), .B(B), .C(C), .arith_sub(arith_sub), .logic_sel(logic_sel),
      .out_valid(ov3), .out_ready(out_ready), .Q(q3), .carry(c3));

   pipeline_alu_vr #(.WIDTH(4), .DEPTH(5)) u5 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir5),
      .A(A), .B(B), .C(C), .arith_sub(arith_sub), .logic_sel(logic_sel),
      .out_valid(ov5), .out_ready(out_ready), .Q(q5), .carry(c5));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      in_valid  = 1'b1;
      A         = va[i];
      B         = vb[i];
      C         = vc[i];
      arith_sub = vs[i];
      logic_sel = vl[i];
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ov", {31'd0, ov3}, 32'd0);
      chk("rst_q", {28'd0, q3}, 32'd0);
      chk("rst_c", {31'd0, c3}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ir", {31'd0, ir3}, 32'd1);

      // Single add/xor: 3+5=8, 8^6=E
      out_ready = 1'b1;
      in_valid = 1'b1; A = 4'h3; B = 4'h5; C = 4'h6; arith_sub = 1'b0; logic_sel = 2'b00;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2_lat_ov", {31'd0, ov3}, 32'd0);
      tick();
      chk("t2_ov", {31'd0, ov3}, 32'd1);
      chk("t2_q", {28'd0, q3}, 32'hE);
      chk("t2_c", {31'd0, c3}, 32'd0);
      tick();
      chk("t2_drain", {31'd0, ov3}, 32'd0);

      // Borrow and wrap: 2-5 pass -> D borrow; F+1 xor 0 -> 0 carry
      in_valid = 1'b1; A = 4'h2; B = 4'h5; C = 4'h9; arith_sub = 1'b1; logic_sel = 2'b11;
      tick();
      A = 4'hF; B = 4'h1; C = 4'h0; arith_sub = 1'b0; logic_sel = 2'b00;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t3a_ov", {31'd0, ov3}, 32'd1);
      chk("t3a_q", {28'd0, q3}, 32'hD);
      chk("t3a_c", {31'd0, c3}, 32'd1);
      tick();
      chk("t3b_ov", {31'd0, ov3}, 32'd1);
      chk("t3b_q", {28'd0, q3}, 32'h0);
      chk("t3b_c", {31'd0, c3}, 32'd1);
      tick();

      // Stream 8 sets back to back
      for (int n = 0; n <= 10; n++) begin
         if (n < 8) drive(n);
         else in_valid = 1'b0;
         tick();
         if (n >= 2 && n <= 9) begin
            chk($sformatf("t4_ov%0d", n-2), {31'd0, ov3}, 32'd1);
            chk($sformatf("t4_q%0d", n-2), {28'd0, q3}, {28'd0, vq[n-2]});
            chk($sformatf("t4_c%0d", n-2), {31'd0, c3}, {31'd0, vk[n-2]});
         end else if (n == 10) begin
            chk("t4_drain", {31'd0, ov3}, 32'd0);
         end
      end

      // Backpressure: fill with vec0..2, stall 5 cycles, then release
      rst = 1'b1; #1; rst = 1'b0;
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         drive(n);
         tick();
      end
      drive(3);
      #1;
      chk("t5_ir_stall", {31'd0, ir3}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         A = 4'(k);
         tick();
         chk($sformatf("t5_ov_hold%0d", k), {31'd0, ov3}, 32'd1);
         chk($sformatf("t5_q_hold%0d", k), {28'd0, q3}, {28'd0, vq[0]});
         chk($sformatf("t5_c_hold%0d", k), {31'd0, c3}, {31'd0, vk[0]});
      end
      drive(3);
      out_ready = 1'b1;
      #1;
      chk("t5_ir_release", {31'd0, ir3}, 32'd1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("t5_ov_out%0d", k), {31'd0, ov3}, 32'd1);
         chk($sformatf("t5_q_out%0d", k), {28'd0, q3}, {28'd0, vq[k]});
         chk($sformatf("t5_c_out%0d", k), {31'd0, c3}, {31'd0, vk[k]});
         tick();
      end
      chk("t5_no_dup", {31'd0, ov3}, 32'd0);

      // Async reset mid-stream
      drive(0); tick();
      drive(1); tick();
      drive(2); tick();
      chk("t1_pre_ov", {31'd0, ov3}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t1_ov", {31'd0, ov3}, 32'd0);
      chk("t1_q", {28'd0, q3}, 32'd0);
      chk("t1_c", {31'd0, c3}, 32'd0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("t1_ir", {31'd0, ir3}, 32'd1);
      tick(); tick(); tick();
      chk("t1_no_ghost", {31'd0, ov3}, 32'd0);

      // DEPTH=5: flush with 3 in flight, flush beats same-cycle accept
      drive(0); tick();
      drive(1); tick();
      drive(2); tick();
      drive(3);
      flush = 1'b1;
      #1;
      chk("t6_ir_flush", {31'd0, ir5}, 32'd1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("t6_ov_flushed", {31'd0, ov5}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t6_empty%0d", k), {31'd0, ov5}, 32'd0);
      end
      drive(4);
      for (int k = 1; k <= 5; k++) begin
         tick();
         in_valid = 1'b0;
         if (k < 5) begin
            chk($sformatf("t6_lat%0d", k), {31'd0, ov5}, 32'd0);
         end else begin
            chk("t6_ov", {31'd0, ov5}, 32'd1);
            chk("t6_q", {28'd0, q5}, {28'd0, vq[4]});
            chk("t6_c", {31'd0, c5}, {31'd0, vk[4]});
         end
      end
      tick();
      chk("t6_drain", {31'd0, ov5}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
